dcache_ctrl: RTL and testbench

Miss-handling and write-back controller for the 2-way, 16-set, 256-bit-line data cache SRAM. It sits between the MEM-stage load/store port and the cache SRAM, and between the cache SRAM and the shared data memory. It serves hits with no stall, and on a miss it writes back a dirty victim, then fetches and installs the new line. It is write-back and write-allocate.

---
 rtl/dcache_ctrl.sv | 98 +++++++++
 tb/tb_dcache_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: write-back/write-allocate miss controller for a 2-way, 16-set, 256-bit-line data cache
// Ports: clk_i/rst_i (async active-high); cpu_* load/store port with stall; sram_* cache array
// lookup/update (set index, tag word {valid,dirty,tag}, line); mem_* registered line requests
// to data memory with a one-cycle mem_ack_i completion pulse.
module dcache_ctrl (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         sram_enable_o,
  output logic         sram_write_o,
  output logic [3:0]   sram_addr_o,
  output logic [24:0]  sram_tag_o,
  output logic [255:0] sram_data_o,
  input  logic [24:0]  sram_tag_i,
  input  logic [255:0] sram_data_i,
  input  logic         sram_hit_i,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);
  typedef enum logic [2:0] {IDLE, MISS, WBACK, ALLOC, REFILL} state_t;
  state_t         state_q;
  logic [255:0]   fill_q;
  logic           mem_en_q, mem_we_q;
  logic [31:0]    mem_addr_q;
  logic [255:0]   mem_data_q;
  logic [255:0]   line_merged;
  logic [2:0]     w;
  logic           idle, refill;
  logic           unused;
  assign unused = ^cpu_addr_i[1:0];
  assign w      = cpu_addr_i[4:2];
  assign idle   = state_q == IDLE;
  assign refill = state_q == REFILL;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fill_q     <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (cpu_req_i && !sram_hit_i) state_q <= MISS;
        MISS: begin
          mem_en_q <= 1'b1;
          if (sram_tag_i[24] && sram_tag_i[23]) begin
            mem_addr_q <= {sram_tag_i[22:0], cpu_addr_i[8:5], 5'b0};
            mem_data_q <= sram_data_i;
            mem_we_q   <= 1'b1;
            state_q    <= WBACK;
          end else begin
            mem_addr_q <= {cpu_addr_i[31:5], 5'b0};
            mem_we_q   <= 1'b0;
            state_q    <= ALLOC;
          end
        end
        WBACK: if (mem_ack_i) begin
          // enable stays high: the fill request follows the write-back back-to-back
          mem_addr_q <= {cpu_addr_i[31:5], 5'b0};
          mem_we_q   <= 1'b0;
          state_q    <= ALLOC;
        end
        ALLOC: if (mem_ack_i) begin
          fill_q   <= mem_data_i;
          mem_en_q <= 1'b0;
          state_q  <= REFILL;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // store word merged into either the hit line (IDLE) or the fetched line (REFILL)
  always_comb begin
    line_merged = refill ? fill_q : sram_data_i;
    line_merged[32*w +: 32] = cpu_data_i;
  end
  assign cpu_data_o    = sram_data_i[32*w +: 32];
  assign cpu_stall_o   = cpu_req_i & ~(idle & sram_hit_i);
  assign sram_enable_o = refill | (idle & cpu_req_i);
  assign sram_write_o  = refill | (idle & cpu_req_i & cpu_write_i & sram_hit_i);
  assign sram_addr_o   = cpu_addr_i[8:5];
  assign sram_tag_o    = {1'b1, refill ? cpu_write_i : 1'b1, cpu_addr_i[31:9]};
  assign sram_data_o   = (refill && !cpu_write_i) ? fill_q : line_merged;
  assign mem_enable_o  = mem_en_q;
  assign mem_write_o   = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_data_o    = mem_data_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed bench for dcache_ctrl with a 2-way LRU cache array model and an acking memory
module tb_dcache_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req_i = 1'b0, cpu_write_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0, cpu_data_i = '0, cpu_data_o;
  logic         cpu_stall_o, sram_enable_o, sram_write_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o, sram_tag_i;
  logic [255:0] sram_data_o, sram_data_i;
  logic         sram_hit_i;
  logic         mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;
  int errors = 0, checks = 0;
  int ack_dly = 0, wait_cnt = 0, n_rd = 0, n_wr = 0;
  logic [31:0]  last_rd_addr = '0, last_wr_addr = '0;
  logic [255:0] last_wr_data = '0;
  always #5 clk = ~clk;
  dcache_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o), .sram_addr_o(sram_addr_o),
    .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o), .sram_tag_i(sram_tag_i),
    .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );
  // cache array: tag words {valid,dirty,tag}, lines, and per-set LRU (way to evict next)
  logic [24:0]  tg_a [16][2];
  logic [255:0] dt_a [16][2];
  logic         lru [16];
  logic         h0, h1, vic, way;
  logic [3:0]   idx;
  always_comb begin
    idx = sram_addr_o;
    h0  = tg_a[idx][0][24] && tg_a[idx][0][22:0] == cpu_addr_i[31:9];
    h1  = tg_a[idx][1][24] && tg_a[idx][1][22:0] == cpu_addr_i[31:9];
    vic = !tg_a[idx][0][24] ? 1'b0 : !tg_a[idx][1][24] ? 1'b1 : lru[idx];
    way = h0 ? 1'b0 : h1 ? 1'b1 : vic;
    sram_hit_i  = h0 | h1;
    sram_tag_i  = tg_a[idx][way];
    sram_data_i = dt_a[idx][way];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 16; s++) begin
        tg_a[s][0] <= '0;
        tg_a[s][1] <= '0;
        lru[s]     <= 1'b0;
      end
    end else if (sram_enable_o && (sram_write_o || sram_hit_i)) begin
      if (sram_write_o) tg_a[idx][way] <= sram_tag_o;
      lru[idx] <= ~way;
    end
  end
  always_ff @(posedge clk) if (sram_enable_o && sram_write_o) dt_a[idx][way] <= sram_data_o;
  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = a + i;
    return r;
  endfunction
  // memory: acks after ack_dly idle cycles of an asserted request
  always @(negedge clk) begin
    mem_ack_i = 1'b0;
    if (mem_enable_o) begin
      if (wait_cnt == ack_dly) begin
        mem_ack_i = 1'b1;
        wait_cnt  = 0;
        if (mem_write_o) begin
          n_wr++;
          last_wr_addr = mem_addr_o;
          last_wr_data = mem_data_o;
        end else begin
          n_rd++;
          last_rd_addr = mem_addr_o;
          mem_data_i   = line_of(mem_addr_o);
        end
      end else wait_cnt++;
    end else wait_cnt = 0;
  end
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // called just after a rising edge; returns stall cycles, load data and tag word on the hit cycle
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int st, output logic [31:0] rd, output logic [24:0] tg);
    cpu_req_i = 1'b1; cpu_write_i = wr; cpu_addr_i = a; cpu_data_i = d; st = 0;
    @(negedge clk);
    while (cpu_stall_o && st < 50) begin
      st++;
      @(negedge clk);
    end
    rd = cpu_data_o;
    tg = sram_tag_i;
    @(posedge clk);
    #1 cpu_req_i = 1'b0; cpu_write_i = 1'b0;
  endtask
  int st;
  logic [31:0] rd;
  logic [24:0] tg;
  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_en", mem_enable_o, 0);
    chk("rst_mem_we", mem_write_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_data", mem_data_o, 0);
    chk("rst_stall", cpu_stall_o, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    ack_dly = 0;
    access(1'b0, 32'h40, 32'h0, st, rd, tg);
    chk("miss_stall", st, 4);
    chk("miss_data", rd, 32'h40);
    chk("miss_rd_addr", last_rd_addr, 32'h40);
    chk("miss_tag", tg, 25'h100_0000);
    chk("miss_nwr", n_wr, 0);
    access(1'b0, 32'h40, 32'h0, st, rd, tg);
    chk("hit_stall", st, 0);
    chk("hit_data", rd, 32'h40);
    chk("hit_nrd", n_rd, 1);
    access(1'b1, 32'h44, 32'hDEAD_BEEF, st, rd, tg);
    chk("sthit_stall", st, 0);
    access(1'b0, 32'h44, 32'h0, st, rd, tg);
    chk("sthit_data", rd, 32'hDEAD_BEEF);
    chk("sthit_tag", tg, 25'h180_0000);
    chk("sthit_data_w0", dt_a[2][0][31:0], 32'h40);
    ack_dly = 2;
    access(1'b1, 32'h240, 32'h1111_1111, st, rd, tg);
    chk("stmiss_stall", st, 6);
    chk("stmiss_tag", tg, 25'h180_0001);
    chk("stmiss_nwr", n_wr, 0);
    access(1'b0, 32'h240, 32'h0, st, rd, tg);
    chk("stmiss_merged", rd, 32'h1111_1111);
    access(1'b0, 32'h244, 32'h0, st, rd, tg);
    chk("stmiss_fill_w1", rd, 32'h241);
    ack_dly = 1;
    access(1'b0, 32'h440, 32'h0, st, rd, tg);
    chk("dirty_stall", st, 7);
    chk("dirty_data", rd, 32'h440);
    chk("dirty_nwr", n_wr, 1);
    chk("dirty_wr_addr", last_wr_addr, 32'h40);
    chk("dirty_wr_w0", last_wr_data[31:0], 32'h40);
    chk("dirty_wr_w1", last_wr_data[63:32], 32'hDEAD_BEEF);
    chk("dirty_rd_addr", last_rd_addr, 32'h440);
    chk("dirty_tag", tg, 25'h100_0002);
    ack_dly = 20;
    cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h1060;
    repeat (2) @(posedge clk);
    #1;
    chk("alloc_en", mem_enable_o, 1);
    chk("alloc_addr", mem_addr_o, 32'h1060);
    chk("alloc_we", mem_write_o, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_en", mem_enable_o, 0);
    chk("arst_addr", mem_addr_o, 0);
    @(negedge clk);
    rst = 1'b0; cpu_req_i = 1'b0;
    @(posedge clk);
    #1;
    ack_dly = 0;
    access(1'b0, 32'h440, 32'h0, st, rd, tg);
    chk("post_rst_stall", st, 4);
    chk("post_rst_data", rd, 32'h440);
    chk("post_rst_nwr", n_wr, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
